// File: rtl/fsic_io_serdes_tx_serializer.sv
// fsic_io_serdes_tx_serializer: ioclk-domain TX serializer with phase-lock qualification.
//   Checks that phase_cnt_in advances by one (mod pCLK_RATIO) every ioclk, locks after
//   pLOCK_CNT consecutive good wraps to zero, captures one parallel word per coreclk at
//   pLOAD_PHASE and shifts it out pLANES bits per ioclk. A training frame is sent while
//   unlocked.
// Ports:
//   ioclk          serializer clock
//   axis_rst       asynchronous active-high reset
//   phase_cnt_in   coreclk phase from the upstream phase counter
//   tx_word_in     parallel word (coreclk domain), with tx_word_vld_in as its valid
//   clear_err      synchronous clear of err_cnt_out (wins over an increment)
//   txd_out        current lane slice, slice 0 first
//   tx_frame_out   high while txd_out carries slice 0
//   lock_out       high while locked
//   lock_lost_out  one-cycle pulse when lock is lost
//   err_cnt_out    saturating count of phase errors seen while locked
module fsic_io_serdes_tx_serializer #(
    parameter int pCLK_RATIO  = 4,
    parameter int pLANES      = 12,
    parameter int pLOAD_PHASE = 1,
    parameter int pLOCK_CNT   = 4,
    localparam int PW = $clog2(pCLK_RATIO),
    localparam int W  = pLANES * pCLK_RATIO
) (
    input  logic              ioclk,
    input  logic              axis_rst,
    input  logic [PW-1:0]     phase_cnt_in,
    input  logic [W-1:0]      tx_word_in,
    input  logic              tx_word_vld_in,
    input  logic              clear_err,
    output logic [pLANES-1:0] txd_out,
    output logic              tx_frame_out,
    output logic              lock_out,
    output logic              lock_lost_out,
    output logic [7:0]        err_cnt_out
);
    localparam int GW = $clog2(pLOCK_CNT + 1);
    localparam logic [1:0] UNLOCK = 2'd0, CHECK = 2'd1, LOCKED = 2'd2;
    // Training word: slice 0 all ones, remaining slices zero.
    localparam logic [W-1:0] TRAIN = W'({pLANES{1'b1}});

    logic [1:0]    state;
    logic [PW-1:0] prev_ph, slot;
    logic          prev_vld;
    logic [GW-1:0] good_cnt;
    logic [W-1:0]  shreg;
    logic          good, mismatch, lost, load;

    assign good     = prev_vld && (phase_cnt_in == prev_ph + PW'(1));
    assign mismatch = prev_vld && !good;
    assign lost     = (state == LOCKED) && mismatch;
    assign load     = phase_cnt_in == PW'(pLOAD_PHASE);

    assign txd_out      = shreg[pLANES-1:0];
    assign tx_frame_out = slot == '0;
    assign lock_out     = state == LOCKED;

    always_ff @(posedge ioclk or posedge axis_rst) begin
        if (axis_rst) begin
            state         <= UNLOCK;
            prev_ph       <= '0;
            prev_vld      <= 1'b0;
            good_cnt      <= '0;
            shreg         <= '0;
            slot          <= PW'(pCLK_RATIO - 1);
            lock_lost_out <= 1'b0;
            err_cnt_out   <= '0;
        end else begin
            prev_ph       <= phase_cnt_in;
            prev_vld      <= 1'b1;
            lock_lost_out <= lost;
            err_cnt_out   <= clear_err ? 8'd0 :
                             (lost && err_cnt_out != 8'hFF) ? err_cnt_out + 8'd1 : err_cnt_out;
            // Any state other than CHECK/LOCKED (incl. illegal codes) restarts qualification;
            // the first sample after reset only seeds prev_ph.
            if (state != CHECK && state != LOCKED) begin
                state    <= CHECK;
                good_cnt <= '0;
            end else if (mismatch) begin
                state    <= CHECK;
                good_cnt <= '0;
            end else if (state == CHECK && good && phase_cnt_in == '0) begin
                if (good_cnt == GW'(pLOCK_CNT - 1)) begin
                    state    <= LOCKED;
                    good_cnt <= '0;
                end else begin
                    good_cnt <= good_cnt + GW'(1);
                end
            end
            if (load) begin
                shreg <= (state == LOCKED) ? (tx_word_vld_in ? tx_word_in : '0) : TRAIN;
                slot  <= '0;
            end else begin
                shreg <= shreg >> pLANES;
                slot  <= (slot == PW'(pCLK_RATIO - 1)) ? slot : slot + PW'(1);
            end
        end
    end
endmodule

// File: tb/tb_fsic_io_serdes_tx_serializer.sv
// tb_fsic_io_serdes_tx_serializer: randomized self-checking bench against a behavioural model.
module tb_fsic_io_serdes_tx_serializer;
    localparam int R = 4, L = 12, W = 48, LOAD = 1, LOCK = 4;

    logic          ioclk = 1'b0;
    logic          axis_rst = 1'b1;
    logic [1:0]    phase_cnt_in = '0;
    logic [W-1:0]  tx_word_in = '0;
    logic          tx_word_vld_in = 1'b0;
    logic          clear_err = 1'b0;
    logic [L-1:0]  txd_out;
    logic          tx_frame_out, lock_out, lock_lost_out;
    logic [7:0]    err_cnt_out;
    logic [22:0]   obs;

    int n_tests = 0, n_fail = 0;

    // Model: word last captured and its age in cycles since capture, plus lock bookkeeping
    bit           m_locked, m_seeded, m_lost;
    int           m_prev, m_wraps, m_err, m_age, ph;
    logic [W-1:0] m_word;

    always #5 ioclk = ~ioclk;

    fsic_io_serdes_tx_serializer dut (
        .ioclk(ioclk), .axis_rst(axis_rst), .phase_cnt_in(phase_cnt_in),
        .tx_word_in(tx_word_in), .tx_word_vld_in(tx_word_vld_in), .clear_err(clear_err),
        .txd_out(txd_out), .tx_frame_out(tx_frame_out), .lock_out(lock_out),
        .lock_lost_out(lock_lost_out), .err_cnt_out(err_cnt_out)
    );

    assign obs = {txd_out, tx_frame_out, lock_out, lock_lost_out, err_cnt_out};

    function automatic void model_reset();
        m_locked = 0; m_seeded = 0; m_lost = 0;
        m_prev = 0; m_wraps = 0; m_err = 0; m_age = R; m_word = '0;
    endfunction

    function automatic logic [22:0] expv();
        logic [L-1:0] t;
        t = (m_age < R) ? m_word[m_age*L +: L] : '0;
        return {t, m_age == 0, m_locked, m_lost, 8'(m_err)};
    endfunction

    function automatic logic [W-1:0] rnd_word();
        return W'({$urandom(), $urandom()});
    endfunction

    task automatic step(input int p, input logic [W-1:0] w, input logic v, input logic c);
        bit mism, good;
        phase_cnt_in = 2'(p); tx_word_in = w; tx_word_vld_in = v; clear_err = c;
        mism = m_seeded && (p != (m_prev + 1) % R);
        good = m_seeded && !mism;
        if (p == LOAD) begin
            m_word = m_locked ? (v ? w : '0) : W'({L{1'b1}});
            m_age = 0;
        end else if (m_age < R) m_age++;
        m_lost = m_locked && mism;
        if (m_lost) begin
            m_locked = 0; m_wraps = 0;
        end else if (!m_locked) begin
            if (mism) m_wraps = 0;
            else if (good && p == 0) begin
                m_wraps++;
                if (m_wraps == LOCK) begin m_locked = 1; m_wraps = 0; end
            end
        end
        m_err = c ? 0 : (m_lost && m_err < 255) ? m_err + 1 : m_err;
        m_prev = p; m_seeded = 1;
        @(posedge ioclk); #1;
    endtask

    task automatic seq(input logic v, input logic c);
        step(ph, rnd_word(), v, c);
        ph = (ph + 1) % R;
    endtask

    task automatic inject(input logic c);
        step((ph + 1) % R, rnd_word(), 1'b1, c);
        ph = (ph + 2) % R;
    endtask

    task automatic test_reset();
        axis_rst = 1'b1;
        model_reset();
        for (int i = 0; i < 8; i++) begin
            phase_cnt_in = 2'($urandom); tx_word_in = rnd_word();
            tx_word_vld_in = 1'($urandom); clear_err = 1'($urandom);
            @(posedge ioclk); #1;
            n_tests++;
            if (obs !== '0) begin
                n_fail++; $display("FAIL reset_hold obs=%h exp=0", obs);
            end
        end
    endtask

    task automatic test_train_lock();
        int locked_at = -1, trains = 0;
        axis_rst = 1'b0; ph = 0;
        for (int i = 0; i < 24; i++) begin
            seq(1'($urandom), 1'b0);
            n_tests++;
            if (obs !== expv()) begin
                n_fail++; $display("FAIL train_lock[%0d] obs=%h exp=%h", i, obs, expv());
            end
            if (lock_out && locked_at < 0) locked_at = i;
            if (!lock_out && tx_frame_out && txd_out == 12'hFFF) trains++;
        end
        n_tests++;
        if (locked_at !== 16) begin
            n_fail++; $display("FAIL lock_cycle got=%0d want=16", locked_at);
        end
        n_tests++;
        if (trains !== 4 || err_cnt_out !== 8'd0) begin
            n_fail++; $display("FAIL train_frames got=%0d err=%0d want=4 err=0", trains, err_cnt_out);
        end
    endtask

    task automatic test_data();
        logic [L-1:0] exp_s [4] = '{12'h654, 12'h987, 12'hCBA, 12'hFED};
        while (ph != LOAD) seq(1'b1, 1'b0);
        step(LOAD, 48'hFED_CBA_987_654, 1'b1, 1'b0);
        ph = (ph + 1) % R;
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (txd_out !== exp_s[k] || tx_frame_out !== (k == 0) || obs !== expv()) begin
                n_fail++;
                $display("FAIL data_slice%0d txd=%h frame=%b want txd=%h frame=%b", k, txd_out,
                         tx_frame_out, exp_s[k], k == 0);
            end
            if (k < 3) seq(1'b1, 1'b0);
        end
    endtask

    task automatic test_lock_loss();
        int relock = -1;
        while (ph != 2) seq(1'b1, 1'b0);
        inject(1'b0);
        n_tests++;
        if (lock_lost_out !== 1'b1 || lock_out !== 1'b0 || err_cnt_out !== 8'd1) begin
            n_fail++;
            $display("FAIL loss lost=%b lock=%b err=%0d want 1 0 1", lock_lost_out, lock_out, err_cnt_out);
        end
        for (int i = 0; i < 20; i++) begin
            seq(1'($urandom), 1'b0);
            n_tests++;
            if (obs !== expv()) begin
                n_fail++; $display("FAIL relock[%0d] obs=%h exp=%h", i, obs, expv());
            end
            if (lock_out && relock < 0) relock = i;
        end
        n_tests++;
        if (relock !== 12) begin
            n_fail++; $display("FAIL relock_cycle got=%0d want=12", relock);
        end
    endtask

    task automatic test_no_valid();
        int frames = 0;
        while (ph != LOAD) seq(1'b1, 1'b0);
        for (int i = 0; i < 12; i++) begin
            seq(1'b0, 1'b0);
            n_tests++;
            if (txd_out !== '0 || obs !== expv()) begin
                n_fail++; $display("FAIL novalid[%0d] obs=%h exp=%h", i, obs, expv());
            end
            frames += tx_frame_out;
        end
        n_tests++;
        if (frames !== 3) begin
            n_fail++; $display("FAIL novalid_frames got=%0d want=3", frames);
        end
    endtask

    task automatic test_mid_reset();
        int locked_at = -1;
        while (ph != LOAD) seq(1'b1, 1'b0);
        step(LOAD, 48'hFED_CBA_987_654, 1'b1, 1'b0);
        axis_rst = 1'b1; #1;
        n_tests++;
        if (obs !== '0) begin
            n_fail++; $display("FAIL mid_reset obs=%h exp=0", obs);
        end
        model_reset();
        #1 axis_rst = 1'b0;
        ph = 0;
        for (int i = 0; i < 20; i++) begin
            seq(1'b1, 1'b0);
            n_tests++;
            if (obs !== expv()) begin
                n_fail++; $display("FAIL mid_relock[%0d] obs=%h exp=%h", i, obs, expv());
            end
            if (lock_out && locked_at < 0) locked_at = i;
        end
        n_tests++;
        if (locked_at !== 16) begin
            n_fail++; $display("FAIL mid_lock_cycle got=%0d want=16", locked_at);
        end
    endtask

    task automatic relock_bounded(output bit ok);
        int n = 0;
        while (!lock_out && n < 40) begin seq(1'b1, 1'b0); n++; end
        ok = lock_out;
    endtask

    task automatic test_saturate();
        bit ok;
        int timeouts = 0;
        for (int k = 0; k < 260; k++) begin
            relock_bounded(ok);
            if (!ok) timeouts++;
            inject(1'b0);
        end
        n_tests++;
        if (timeouts != 0) begin
            n_fail++; $display("FAIL sat_relock timeouts=%0d want=0", timeouts);
        end
        n_tests++;
        if (err_cnt_out !== 8'd255 || obs !== expv()) begin
            n_fail++; $display("FAIL sat_err got=%0d want=255", err_cnt_out);
        end
        relock_bounded(ok);
        inject(1'b1);
        n_tests++;
        if (!ok || err_cnt_out !== 8'd0 || lock_lost_out !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_vs_loss err=%0d lost=%b lock_ok=%b want 0 1 1", err_cnt_out, lock_lost_out, ok);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(11) == 0) inject(1'($urandom_range(49) == 0));
            else seq(1'($urandom), 1'($urandom_range(49) == 0));
            n_tests++;
            if (obs !== expv()) begin
                n_fail++; $display("FAIL random[%0d] obs=%h exp=%h", i, obs, expv());
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_train_lock();
        test_data();
        test_lock_loss();
        test_no_valid();
        test_mid_reset();
        test_saturate();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
